lp_fir_mc: RTL

Parametrised, multi-channel, time-multiplexed FIR low-pass filter. It is the next-generation LP engine behind the filter wrapper, generalising the single LP instance to CH channels, TAPS taps and run-time coefficients. One shared multiplier-accumulator serves all channels. It keeps the start/valid/err handshake of the existing LP block and adds bypass mode, overrun detection and output saturation.

---
 rtl/lp_fir_mc.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/lp_fir_mc.sv
// ============================================================================
// Module   : lp_fir_mc
// Purpose  : Multi-channel time-multiplexed FIR low-pass filter sharing one MAC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lp_fir_mc #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int CH     = 6,
  parameter int SHIFT  = 15,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH*DATA_W-1:0]     data_in,
  input  logic                     start,
  input  logic                     bypass,
  input  logic [1:0]               err_in,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [CH*DATA_W-1:0]     data_out,
  output logic                     valid,
  output logic                     busy,
  output logic [1:0]               err_out
);

  localparam int TAP_W = $clog2(TAPS);
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int RND_W = ACC_W + 1;
  localparam logic signed [COEF_W-1:0] COEF_RST = COEF_W'((2 ** SHIFT) / TAPS);
  localparam logic signed [RND_W-1:0]  ONE      = 1;
  localparam logic signed [RND_W-1:0]  RND      = ONE <<< (SHIFT - 1);
  localparam logic signed [RND_W-1:0]  SAT_MAX  = (ONE <<< (DATA_W - 1)) - ONE;
  localparam logic signed [RND_W-1:0]  SAT_MIN  = -(ONE <<< (DATA_W - 1));
  localparam logic [TAP_W-1:0]         TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic [CH_W-1:0]          CH_LAST  = CH_W'(CH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic [CH_W-1:0]           ch_q, ch_d;

  logic signed [DATA_W-1:0]  line_q [CH][TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [ACC_W-1:0]   hold_q [CH];
  logic                      byp_q;
  logic [1:0]                errl_q;
  logic                      ovr_q;
  logic [CH*DATA_W-1:0]      data_out_q;
  logic                      valid_q;
  logic                      busy_q;
  logic [1:0]                err_q;

  logic signed [DATA_W+COEF_W-1:0] w_prod;
  logic signed [ACC_W-1:0]         w_sum;
  logic                            w_tap_wrap;
  logic signed [RND_W-1:0]         w_y [CH];
  logic [CH*DATA_W-1:0]            w_dout;
  logic                            w_sat_any;

  assign w_prod     = line_q[ch_q][tap_q] * coef_q[tap_q];
  assign w_sum      = acc_q + ACC_W'(w_prod);
  assign w_tap_wrap = (tap_q == TAP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      tap_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tap_d   = tap_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          acc_d   = '0;
          tap_d   = '0;
          ch_d    = '0;
        end
      end
      S_MAC: begin
        // Tap counter is the inner loop; a wrap closes out one channel.
        if (w_tap_wrap) begin
          tap_d = '0;
          acc_d = '0;
          if (ch_q == CH_LAST) begin
            state_d = S_DONE;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end else begin
          tap_d = tap_q + 1'b1;
          acc_d = w_sum;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_dout    = '0;
    w_sat_any = 1'b0;
    for (int k = 0; k < CH; k++) begin
      w_y[k] = ($signed({hold_q[k][ACC_W-1], hold_q[k]}) + RND) >>> SHIFT;
      if (byp_q) begin
        w_dout[k*DATA_W +: DATA_W] = line_q[k][0];
      end else if (w_y[k] > SAT_MAX) begin
        w_dout[k*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
        w_sat_any                  = 1'b1;
      end else if (w_y[k] < SAT_MIN) begin
        w_dout[k*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
        w_sat_any                  = 1'b1;
      end else begin
        w_dout[k*DATA_W +: DATA_W] = w_y[k][DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) begin
        hold_q[k] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          line_q[k][t] <= '0;
        end
      end
      for (int t = 0; t < TAPS; t++) begin
        coef_q[t] <= COEF_RST;
      end
      byp_q      <= 1'b0;
      errl_q     <= '0;
      ovr_q      <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (coef_we) begin
            coef_q[coef_addr] <= coef_data;
          end
          if (start) begin
            for (int k = 0; k < CH; k++) begin
              line_q[k][0] <= data_in[k*DATA_W +: DATA_W];
              for (int t = 1; t < TAPS; t++) begin
                line_q[k][t] <= line_q[k][t-1];
              end
            end
            byp_q  <= bypass;
            errl_q <= err_in;
            busy_q <= 1'b1;
          end
        end
        S_MAC: begin
          // Start arriving mid-computation is dropped but remembered for the report.
          if (start) begin
            ovr_q <= 1'b1;
          end
          if (w_tap_wrap) begin
            hold_q[ch_q] <= w_sum;
          end
        end
        S_DONE: begin
          data_out_q <= w_dout;
          valid_q    <= 1'b1;
          busy_q     <= 1'b0;
          err_q      <= {errl_q[1] | ovr_q, errl_q[0] | w_sat_any};
          ovr_q      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign err_out  = err_q;

endmodule

`default_nettype wire
